univ_shift_reg: RTL

Parametrised universal shift register. Successor to the fixed 4-bit load/shift-right register.
- Adds configurable width and a mode-selected operation set: hold, load, logical shift left/right, rotate left/right, arithmetic shift right.
- Adds a burst engine that performs a programmed number of shifts autonomously, with busy/done status.
- Used in serializer/deserializer and bit-manipulation datapaths.

---
 rtl/univ_sr_pkg.sv | 30 +++
 rtl/univ_shift_reg_if.sv | 40 ++++
 rtl/univ_sr_next.sv | 26 ++
 rtl/univ_shift_reg.sv | 94 +++++++++
 4 files changed

// File: rtl/univ_sr_pkg.sv
// Shared encodings for the universal shift register: operation modes,
// burst FSM states and burst counter sizing.
package univ_sr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'd0,
    MODE_LOAD  = 3'd1,
    MODE_SHR   = 3'd2,
    MODE_SHL   = 3'd3,
    MODE_ROR   = 3'd4,
    MODE_ROL   = 3'd5,
    MODE_ASR   = 3'd6,
    MODE_HOLD7 = 3'd7
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic logic is_shift(input mode_e m);
    return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
           (m == MODE_ROL) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register.
// UNIV_SR_ABORT_EN adds the burst abort input.
interface univ_shift_reg_if
  import univ_sr_pkg::*;
#(
  parameter int WIDTH = 8
) ();
  localparam int CNT_W = cnt_w(WIDTH);

  logic [2:0]       mode;
  logic [WIDTH-1:0] din;
  logic             sin_r;
  logic             sin_l;
  logic             start;
  logic [CNT_W-1:0] count;
`ifdef UNIV_SR_ABORT_EN
  logic             abort;
`endif
  logic [WIDTH-1:0] qout;
  logic             sout_r;
  logic             sout_l;
  logic             busy;
  logic             done;

  modport master (
    output mode, din, sin_r, sin_l, start, count,
`ifdef UNIV_SR_ABORT_EN
    output abort,
`endif
    input  qout, sout_r, sout_l, busy, done
  );

  modport slave (
    input  mode, din, sin_r, sin_l, start, count,
`ifdef UNIV_SR_ABORT_EN
    input  abort,
`endif
    output qout, sout_r, sout_l, busy, done
  );
endinterface

// File: rtl/univ_sr_next.sv
// Combinational next-value unit: applies one operation to the register value.
module univ_sr_next
  import univ_sr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  mode_e            op_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             sin_r_i,
  input  logic             sin_l_i,
  output logic [WIDTH-1:0] q_o
);
  always_comb begin
    q_o = q_i;
    case (op_i)
      MODE_LOAD: q_o = din_i;
      MODE_SHR:  q_o = {sin_r_i, q_i[WIDTH-1:1]};
      MODE_SHL:  q_o = {q_i[WIDTH-2:0], sin_l_i};
      MODE_ROR:  q_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_ROL:  q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ASR:  q_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      default:   q_o = q_i;
    endcase
  end
endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with autonomous burst engine.
// Define UNIV_SR_ABORT_EN to allow a running burst to be aborted.
module univ_shift_reg
  import univ_sr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  univ_shift_reg_if.slave  bus
);
  localparam int CNT_W = cnt_w(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  mode_e            bmode_q, bmode_d;
  logic             done_q, done_d;
  mode_e            op;
  mode_e            mode_in;

  assign mode_in = mode_e'(bus.mode);

  univ_sr_next #(.WIDTH(WIDTH)) u_next (
    .q_i     (q_q),
    .op_i    (op),
    .din_i   (bus.din),
    .sin_r_i (bus.sin_r),
    .sin_l_i (bus.sin_l),
    .q_o     (q_d)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    bmode_d = bmode_q;
    done_d  = 1'b0;
    op      = mode_in;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_shift(mode_in) && (bus.count != '0)) begin
            // First shift of the burst happens on the accepting edge.
            bmode_d = mode_in;
            rem_d   = bus.count - 1'b1;
            if (bus.count == CNT_W'(1)) done_d  = 1'b1;
            else                        state_d = ST_BURST;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_BURST: begin
        op    = bmode_q;
        rem_d = rem_q - 1'b1;
        if (rem_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
`ifdef UNIV_SR_ABORT_EN
        if (bus.abort) begin
          op      = MODE_HOLD;
          rem_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q     <= '0;
      state_q <= ST_IDLE;
      rem_q   <= '0;
      bmode_q <= MODE_HOLD;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      bmode_q <= bmode_d;
      done_q  <= done_d;
    end
  end

  assign bus.qout   = q_q;
  assign bus.sout_r = q_q[0];
  assign bus.sout_l = q_q[WIDTH-1];
  assign bus.busy   = (state_q == ST_BURST);
  assign bus.done   = done_q;
endmodule
